// File: rtl/write_pump_reader_if.sv
// write_pump_reader_if
// Groups the RAM read port, the half-full/release handshake toward the
// filler and the byte stream toward the medium writer.
//   HALF_FULL      filler -> reader   per-half "sector complete" level
//   HALF_RELEASE   reader -> filler   one-cycle "half drained" pulse
//   RADDR_SW_PUMP  reader -> RAM      read address
//   RENA_SW_PUMP   reader -> RAM      read enable
//   Q_SW_PUMP      RAM -> reader      read data, one cycle after RENA
//   DOUT/DOUT_VALID/DOUT_READY        byte stream, valid/ready
//   BUSY, CUR_HALF                    status
// Modport master is the reader's view, slave is the environment's view.
interface write_pump_reader_if #(
    parameter int ADDR_W = 10
);
    logic [1:0]        HALF_FULL;
    logic [1:0]        HALF_RELEASE;
    logic [ADDR_W-1:0] RADDR_SW_PUMP;
    logic              RENA_SW_PUMP;
    logic [7:0]        Q_SW_PUMP;
    logic [7:0]        DOUT;
    logic              DOUT_VALID;
    logic              DOUT_READY;
    logic              BUSY;
    logic              CUR_HALF;

    modport master (
        input  HALF_FULL,
        input  Q_SW_PUMP,
        input  DOUT_READY,
        output HALF_RELEASE,
        output RADDR_SW_PUMP,
        output RENA_SW_PUMP,
        output DOUT,
        output DOUT_VALID,
        output BUSY,
        output CUR_HALF
    );

    modport slave (
        output HALF_FULL,
        output Q_SW_PUMP,
        output DOUT_READY,
        input  HALF_RELEASE,
        input  RADDR_SW_PUMP,
        input  RENA_SW_PUMP,
        input  DOUT,
        input  DOUT_VALID,
        input  BUSY,
        input  CUR_HALF
    );
endinterface

// File: rtl/write_pump_reader.sv
// write_pump_reader
// Drains one 512-byte half of the write-pump ping-pong RAM at a time, in
// strict alternation starting with half 0, and streams the bytes out on a
// valid/ready interface. After the last byte of a half is accepted the half
// is handed back to the filler with a one-cycle HALF_RELEASE pulse.
// Ports:
//   CLK  clock, all logic on posedge
//   RST  synchronous active-high reset
//   bus  write_pump_reader_if.master (RAM read port, half handshake,
//        byte stream, status)
module write_pump_reader #(
    parameter int HALF_WORDS = 512,
    parameter int ADDR_W     = 10
) (
    input  logic                CLK,
    input  logic                RST,
    write_pump_reader_if.master bus
);

    localparam logic [ADDR_W-1:0] HALF_CNT  = ADDR_W'(HALF_WORDS);
    localparam logic [ADDR_W-1:0] HALF_LAST = ADDR_W'(HALF_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STREAM = 2'b01,
        DONE   = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              cur_half_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] issued_r;
    logic [ADDR_W-1:0] accepted_r;
    logic              inflight_r;
    logic [1:0]        fifo_cnt_r;
    logic [1:0]        fifo_cnt_s;
    logic [7:0]        head_r;
    logic [7:0]        tail_r;
    logic              dout_valid_r;
    logic [1:0]        release_r;
    logic [1:0]        release_s;
    logic              busy_r;

    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic              last_pop_s;
    logic [2:0]        occupancy_s;

    // Handshake, RAM return and projected FIFO occupancy for the issue check.
    // A pop implies the FIFO is non-empty, so the subtraction cannot wrap.
    always_comb begin
        pop_s       = dout_valid_r & bus.DOUT_READY;
        push_s      = inflight_r;
        occupancy_s = {1'b0, fifo_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        last_pop_s  = pop_s & (accepted_r == HALF_LAST);
        fifo_cnt_s  = fifo_cnt_r + {1'b0, push_s} - {1'b0, pop_s};
    end

    // Next-state, read issue and release decode.
    always_comb begin
        state_s   = state_r;
        issue_s   = 1'b0;
        release_s = 2'b00;
        case (state_r)
            IDLE: begin
                // Only the half whose turn it is matters; the other is ignored.
                if (bus.HALF_FULL[cur_half_r]) begin
                    state_s = STREAM;
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                // Issue only if the byte still fits once everything already
                // buffered or in flight has landed, assuming no further pops.
                if ((issued_r < HALF_CNT) && (occupancy_s < 3'd2)) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
                if (last_pop_s) begin
                    state_s   = DONE;
                    release_s = cur_half_r ? 2'b10 : 2'b01;
                end else begin
                    state_s = STREAM;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register, pointer/counters, half selector and status registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            cur_half_r <= 1'b0;
            ptr_r      <= '0;
            issued_r   <= '0;
            accepted_r <= '0;
            inflight_r <= 1'b0;
            release_r  <= 2'b00;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            inflight_r <= issue_s;
            release_r  <= release_s;
            busy_r     <= (state_s != IDLE);
            if ((state_r == IDLE) && (state_s == STREAM)) begin
                ptr_r      <= {cur_half_r, {(ADDR_W-1){1'b0}}};
                issued_r   <= '0;
                accepted_r <= '0;
            end else begin
                if (issue_s) begin
                    // Top bit holds the half; only the offset advances.
                    ptr_r    <= {ptr_r[ADDR_W-1], ptr_r[ADDR_W-2:0] + (ADDR_W-1)'(1)};
                    issued_r <= issued_r + ADDR_W'(1);
                end
                if (pop_s) begin
                    accepted_r <= accepted_r + ADDR_W'(1);
                end
            end
            if (state_r == DONE) begin
                cur_half_r <= ~cur_half_r;
            end
        end
    end

    // Two-entry output FIFO: head_r drives DOUT, tail_r absorbs the byte
    // still in flight when the consumer stalls.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fifo_cnt_r   <= 2'd0;
            head_r       <= 8'h00;
            tail_r       <= 8'h00;
            dout_valid_r <= 1'b0;
        end else begin
            fifo_cnt_r   <= fifo_cnt_s;
            dout_valid_r <= (fifo_cnt_s != 2'd0);
            case ({push_s, pop_s})
                2'b10: begin
                    if (fifo_cnt_r == 2'd0) begin
                        head_r <= bus.Q_SW_PUMP;
                    end else begin
                        tail_r <= bus.Q_SW_PUMP;
                    end
                end
                2'b01: begin
                    if (fifo_cnt_r == 2'd2) begin
                        head_r <= tail_r;
                    end
                end
                2'b11: begin
                    if (fifo_cnt_r == 2'd2) begin
                        head_r <= tail_r;
                        tail_r <= bus.Q_SW_PUMP;
                    end else begin
                        head_r <= bus.Q_SW_PUMP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.RENA_SW_PUMP  = issue_s;
    assign bus.RADDR_SW_PUMP = ptr_r;
    assign bus.DOUT          = head_r;
    assign bus.DOUT_VALID    = dout_valid_r;
    assign bus.HALF_RELEASE  = release_r;
    assign bus.BUSY          = busy_r;
    assign bus.CUR_HALF      = cur_half_r;

endmodule

// File: tb/tb_write_pump_reader.sv
// tb_write_pump_reader
// Scoreboard bench: each test pushes the byte sequence and release pulses
// it expects; a negedge monitor pops and compares on every stream handshake
// and every release pulse, and also watches stall stability and the
// buffered-plus-in-flight bound.
module tb_write_pump_reader;
    localparam int HW = 512;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    write_pump_reader_if #(.ADDR_W(AW)) bus ();

    write_pump_reader #(.HALF_WORDS(HW), .ADDR_W(AW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.master)
    );

    // RAM content: half 0 holds addr[7:0]; half 1 is scrambled so halves differ.
    function automatic logic [7:0] mem_val(input logic [9:0] a);
        return a[7:0] ^ (a[9] ? 8'hA5 : 8'h00);
    endfunction

    // Synchronous RAM read port model.
    always @(posedge clk) begin
        if (bus.RENA_SW_PUMP) bus.Q_SW_PUMP <= mem_val(bus.RADDR_SW_PUMP);
    end

    logic [7:0] exp_q[$];
    logic [1:0] rel_q[$];
    int   hs_cnt = 0;
    int   rd_cnt = 0;
    int   rel_cnt = 0;
    int   last_hs_edge = 0;
    int   rel_cyc = 0;
    bit   prev_stall = 1'b0;
    bit   prev_rel = 1'b0;
    logic [7:0] prev_dout = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: sample away from the active edge and score everything.
    always @(negedge clk) begin
        logic [7:0] e;
        logic [1:0] r;
        int outst;
        bit pop;
        if (rst) begin
            exp_q.delete();
            rel_q.delete();
            hs_cnt = 0;
            rd_cnt = 0;
            prev_stall = 1'b0;
            prev_rel = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_held", bus.DOUT_VALID, 1);
                chk("stall_dout_held", bus.DOUT, prev_dout);
            end
            pop = bus.DOUT_VALID && bus.DOUT_READY;
            if (bus.RENA_SW_PUMP) begin
                outst = rd_cnt + 1 - hs_cnt - (pop ? 1 : 0);
                total++;
                if (outst > 2) begin
                    bad++;
                    $display("FAIL buffer_bound: outstanding=%0d limit=2", outst);
                end
                rd_cnt++;
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_byte: actual=%0h expected=none", bus.DOUT);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_byte", bus.DOUT, e);
                end
                hs_cnt++;
                last_hs_edge = cyc + 1;
            end
            if (bus.HALF_RELEASE != 2'b00) begin
                chk("release_one_cycle", prev_rel, 0);
                if (rel_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_release: actual=%0b expected=none", bus.HALF_RELEASE);
                end else begin
                    r = rel_q.pop_front();
                    chk("release_half", bus.HALF_RELEASE, r);
                end
                rel_cnt++;
                rel_cyc = cyc;
            end
            prev_rel   = (bus.HALF_RELEASE != 2'b00);
            prev_stall = bus.DOUT_VALID && !bus.DOUT_READY;
            prev_dout  = bus.DOUT;
        end
    end

    task automatic push_half(input int h);
        for (int i = 0; i < HW; i++) exp_q.push_back(mem_val(10'(h * HW + i)));
        rel_q.push_back(h == 0 ? 2'b01 : 2'b10);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.HALF_FULL = 2'b00;
        bus.DOUT_READY = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_dout_valid", bus.DOUT_VALID, 0);
        chk("rst_dout", bus.DOUT, 8'h00);
        chk("rst_rena", bus.RENA_SW_PUMP, 0);
        chk("rst_raddr", bus.RADDR_SW_PUMP, 0);
        chk("rst_release", bus.HALF_RELEASE, 2'b00);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_cur_half", bus.CUR_HALF, 0);
    endtask

    // Wait (bounded) until the release count reaches target; optional random READY.
    task automatic wait_rel(input int target, input int budget, input bit rnd);
        int n = 0;
        while (rel_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            if (rnd) bus.DOUT_READY = 1'($urandom_range(0, 1));
            n++;
        end
        bus.DOUT_READY = 1'b1;
        chk("release_wait", rel_cnt, target);
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("handshake_wait", (hs_cnt >= target) ? 1 : 0, 1);
    endtask

    initial begin
        int k;
        int d;
        int r0;
        rst = 1'b1;
        bus.HALF_FULL = 2'b00;
        bus.DOUT_READY = 1'b1;

        // T1: half 0, READY=1, latency and release timing
        do_reset();
        @(posedge clk); #1;
        bus.HALF_FULL = 2'b01;
        push_half(0);
        k = cyc + 1;
        @(negedge clk); chk("t1_no_read_before_k", bus.RENA_SW_PUMP, 0);
        @(negedge clk); chk("t1_first_rena", bus.RENA_SW_PUMP, 1);
        chk("t1_first_raddr", bus.RADDR_SW_PUMP, 0);
        @(negedge clk); chk("t1_valid_low_k2", bus.DOUT_VALID, 0);
        @(negedge clk); chk("t1_valid_high_k3", bus.DOUT_VALID, 1);
        wait_rel(rel_cnt + 1, 700, 1'b0);
        chk("t1_last_handshake_edge", last_hs_edge, k + 514);
        chk("t1_release_cycle", rel_cyc, k + 514);
        chk("t1_cur_half", bus.CUR_HALF, 1);
        chk("t1_busy_idle", bus.BUSY, 0);
        bus.HALF_FULL = 2'b00;
        chk("t1_all_bytes", exp_q.size(), 0);

        // T2: both halves full, strict alternation, back-to-back gap
        do_reset();
        @(posedge clk); #1;
        bus.HALF_FULL = 2'b11;
        push_half(0);
        push_half(1);
        r0 = rel_cnt;
        wait_rel(r0 + 1, 700, 1'b0);
        d = rel_cyc;
        @(negedge clk); chk("t2_gap_no_rena", bus.RENA_SW_PUMP, 0);
        chk("t2_gap_cycle", cyc, d + 1);
        @(negedge clk); chk("t2_next_rena", bus.RENA_SW_PUMP, 1);
        chk("t2_next_raddr", bus.RADDR_SW_PUMP, 512);
        wait_rel(r0 + 2, 700, 1'b0);
        bus.HALF_FULL = 2'b00;
        chk("t2_cur_half", bus.CUR_HALF, 0);
        chk("t2_all_bytes", exp_q.size(), 0);

        // T3: random READY over a full half
        do_reset();
        @(posedge clk); #1;
        bus.HALF_FULL = 2'b01;
        push_half(0);
        wait_rel(rel_cnt + 1, 3000, 1'b1);
        bus.HALF_FULL = 2'b00;
        chk("t3_all_bytes", exp_q.size(), 0);

        // T4: only the wrong half full -> nothing happens; then bit 0
        do_reset();
        bus.HALF_FULL = 2'b10;
        repeat (20) @(posedge clk);
        #1;
        chk("t4_busy", bus.BUSY, 0);
        chk("t4_no_reads", rd_cnt, 0);
        chk("t4_cur_half", bus.CUR_HALF, 0);
        bus.HALF_FULL = 2'b11;
        push_half(0);
        wait_rel(rel_cnt + 1, 700, 1'b0);
        bus.HALF_FULL = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        chk("t4_busy_after", bus.BUSY, 0);
        chk("t4_cur_half_after", bus.CUR_HALF, 1);
        chk("t4_all_bytes", exp_q.size(), 0);

        // T5: reset at byte 200, then a clean re-run from address 0
        do_reset();
        bus.HALF_FULL = 2'b01;
        push_half(0);
        wait_hs(200, 400);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_valid_after_rst", bus.DOUT_VALID, 0);
        chk("t5_rena_after_rst", bus.RENA_SW_PUMP, 0);
        chk("t5_cur_half_after_rst", bus.CUR_HALF, 0);
        chk("t5_release_after_rst", bus.HALF_RELEASE, 2'b00);
        chk("t5_busy_after_rst", bus.BUSY, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        push_half(0);
        @(negedge clk);
        @(negedge clk);
        chk("t5_rerun_rena", bus.RENA_SW_PUMP, 1);
        chk("t5_rerun_raddr", bus.RADDR_SW_PUMP, 0);
        wait_rel(rel_cnt + 1, 700, 1'b0);
        bus.HALF_FULL = 2'b00;
        chk("t5_all_bytes", exp_q.size(), 0);

        // T6: HALF_FULL[0] dropped at byte 10, half still fully drained
        do_reset();
        bus.HALF_FULL = 2'b01;
        push_half(0);
        wait_hs(10, 100);
        bus.HALF_FULL = 2'b00;
        wait_rel(rel_cnt + 1, 700, 1'b0);
        chk("t6_cur_half", bus.CUR_HALF, 1);
        chk("t6_all_bytes", exp_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/write_pump_reader.md
# write_pump_reader

Drains the 1024x8 write-pump ping-pong buffer, the consumer end of the path that fills it sector by sector. Each 512-byte half is signalled full by the filling side. This block reads that half sequentially from the RAM read port and streams it out as bytes on a valid/ready interface toward the medium writer. Once the last byte of a half has been accepted, it returns the half to the filler with a one-cycle release pulse.

## Interface
- HALF_WORDS, 512: bytes per half; power of two; base of half h = h*HALF_WORDS.
- ADDR_W, 10: RAM address width, equal to log2(2*HALF_WORDS).
- CLK  in  1  single clock; all logic on posedge.
- RST  in  1  reset; synchronous, active-high.
- HALF_FULL  in  2  level; bit h=1 means half h holds a complete sector.
- HALF_RELEASE  out  2  one-cycle pulse on bit h when half h has been fully drained.
- RADDR_SW_PUMP  out  ADDR_W  RAM read address.
- RENA_SW_PUMP  out  1  RAM read enable.
- Q_SW_PUMP  in  8  RAM read data; valid exactly one cycle after the RENA cycle.
- DOUT  out  8  stream byte.
- DOUT_VALID  out  1  DOUT holds a byte.
- DOUT_READY  in  1  consumer accepts DOUT when DOUT_VALID=1 and DOUT_READY=1 at the same edge.
- BUSY  out  1  high in STREAM and DONE.
- CUR_HALF  out  1  half being served or next to be served.

## Operation
- FSM states: IDLE, STREAM, DONE.
- IDLE
  - No reads are issued.
  - If HALF_FULL[CUR_HALF]=1, go to STREAM and load the read pointer with CUR_HALF*HALF_WORDS.
  - HALF_FULL[!CUR_HALF] is ignored. Halves are always served strictly alternately, starting with half 0.
- STREAM
  - A read is issued (RENA_SW_PUMP=1, RADDR=pointer, pointer+1) when issued<HALF_WORDS and (fifo_count + inflight − pop) < 2.
  - pop is the handshake occurring this cycle. inflight is 1 if a read was issued in the previous cycle.
  - Returned data is pushed into a 2-entry output FIFO. DOUT and DOUT_VALID are driven from the FIFO head register.
  - Pointer arithmetic is modulo HALF_WORDS inside the half; the pointer never crosses into the other half.
  - Once HALF_WORDS bytes have been issued, RENA stays 0.
  - On the handshake of byte HALF_WORDS, go to DONE.
- DONE (one cycle)
  - HALF_RELEASE[CUR_HALF]=1.
  - CUR_HALF toggles.
  - Go to IDLE.
- Counters: issued count and accepted count are each ADDR_W bits wide and count 0..HALF_WORDS.
- HALF_FULL deasserting during STREAM is ignored; the half is drained completely.
- DOUT_READY low stalls the stream: no overflow and no byte loss. The FIFO absorbs the one in-flight byte.
- DOUT and DOUT_VALID must not change while DOUT_VALID=1 and DOUT_READY=0.

## Timing
- Reset values: FSM=IDLE, CUR_HALF=0, DOUT_VALID=0, DOUT=8'h00, RENA_SW_PUMP=0, RADDR_SW_PUMP=0, HALF_RELEASE=2'b00, BUSY=0, FIFO empty, counters 0.
- Reset mid-stream aborts the half without a release pulse. The filler owns recovery.
- Start latency: let edge k be the edge at which IDLE samples HALF_FULL[CUR_HALF]=1.
  - Edge k+1: first RENA.
  - Edge k+2: Q captured.
  - Edge k+3: DOUT_VALID=1.
- Throughput: 1 byte/cycle while DOUT_READY=1.
- With DOUT_READY held high, the 512th handshake falls at edge k+3+511.
- DONE (release pulse) follows in the next cycle.
- IDLE is re-entered one cycle after DONE.
- Back-to-back halves: the earliest next RENA is 2 cycles after DONE.
- Stall, then resume: no byte is duplicated or skipped. Order is strictly ascending address.
- Simultaneous push and pop with FIFO full: legal, and count is unchanged.
- Simultaneous DONE and HALF_FULL change: only the new CUR_HALF is evaluated, in IDLE.

## Test plan
- Reset, then HALF_FULL=01, RAM half 0 holding byte=addr[7:0], READY=1 -> 512 bytes 00..FF,00..FF. First VALID at k+3. HALF_RELEASE=01 for exactly 1 cycle. CUR_HALF→1.
- HALF_FULL=11 from start -> half 0 then half 1 (addresses 0..511, then 512..1023), RELEASE 01 then 10, no interleaving.
- Random DOUT_READY (50%) over a full half -> byte sequence identical to the READY=1 run. DOUT stable during each stall. RENA never has more than 2 bytes buffered plus in flight.
- HALF_FULL=10 only at start -> no reads, BUSY=0. Then assert bit 0 -> half 0 served.
- RST asserted at byte 200 of half 0 -> next cycle DOUT_VALID=0, RENA=0, CUR_HALF=0, no RELEASE. A re-run restarts at address 0.
- HALF_FULL[0] dropped at byte 10 -> all 512 bytes still delivered, and RELEASE=01 is issued.
